seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 100 ++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// Six-page hex debug display: debounced page button, 4-digit multiplexed scan,
// and a snapshot register so each full scan shows one coherent 16-bit word.
module seg_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic [15:0] val4,
  input  logic [15:0] val5,
  input  logic [15:0] val6,
  input  logic        btn,
  output logic [2:0]  page,
  output logic [3:0]  dig,
  output logic [7:0]  seg
);
  localparam int SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic          deb, deb_d;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   snap, snap_nxt, val_sel;
  logic [3:0]    nib;
  logic          term;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    case (page)
      3'd0:    val_sel = val1;
      3'd1:    val_sel = val2;
      3'd2:    val_sel = val3;
      3'd3:    val_sel = val4;
      3'd4:    val_sel = val5;
      default: val_sel = val6;
    endcase
    term    = (scan_cnt == SW'(SCAN_DIV - 1));
    idx_nxt = idx + 2'd1;
    // On the 3->0 wrap digit 0 must come from the word being captured now
    snap_nxt = (idx == 2'd3) ? val_sel : snap;
    case (idx_nxt)
      2'd0:    nib = snap_nxt[3:0];
      2'd1:    nib = snap_nxt[7:4];
      2'd2:    nib = snap_nxt[11:8];
      default: nib = snap_nxt[15:12];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync     <= '0;
      deb      <= 1'b0;
      deb_d    <= 1'b0;
      deb_cnt  <= '0;
      page     <= '0;
      scan_cnt <= '0;
      idx      <= '0;
      snap     <= '0;
      dig      <= 4'b1110;
      seg      <= 8'hC0;
    end else begin
      sync  <= {sync[0], btn};
      deb_d <= deb;
      if (sync[1] != deb) begin
        if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          deb     <= ~deb;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
      if (deb && !deb_d)
        page <= (page == 3'd5) ? 3'd0 : page + 3'd1;
      if (term) begin
        scan_cnt <= '0;
        idx      <= idx_nxt;
        snap     <= snap_nxt;
        dig      <= ~(4'b0001 << idx_nxt);
        seg      <= {~((idx_nxt == 2'd0) && deb), ~hex7(nib)};
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end
endmodule
